// File: rtl/alu_pkg.sv
// Shared ALU operation encoding, used by the decode-side ALU control and by the EX-stage ALU.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND     = 4'b0000;
  localparam alu_op_t ALU_OR      = 4'b0001;
  localparam alu_op_t ALU_SUM     = 4'b0010;
  localparam alu_op_t ALU_EQUAL   = 4'b0011;
  localparam alu_op_t ALU_SLL     = 4'b0100;
  localparam alu_op_t ALU_SRL     = 4'b0101;
  localparam alu_op_t ALU_SRA     = 4'b0111;
  localparam alu_op_t ALU_XOR     = 4'b1000;
  localparam alu_op_t ALU_NOR     = 4'b1001;
  localparam alu_op_t ALU_SUB     = 4'b1010;
  localparam alu_op_t ALU_GE      = 4'b1100;
  localparam alu_op_t ALU_GE_U    = 4'b1101;
  localparam alu_op_t ALU_SLT     = 4'b1110;
  localparam alu_op_t ALU_SLT_U   = 4'b1111;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Single-cycle ALU ops: logic, add/sub and compares. Shift and unused codes yield 0.
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  logic flag;

  always_comb begin
    result = '0;
    flag   = 1'b0;
    case (op)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_SUM:   result = a + b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SUB:   result = a - b;
      // compares produce a zero-extended 0/1
      ALU_EQUAL: begin flag = (a == b);                   result = {{(DATA_WIDTH-1){1'b0}}, flag}; end
      ALU_GE:    begin flag = ($signed(a) >= $signed(b)); result = {{(DATA_WIDTH-1){1'b0}}, flag}; end
      ALU_GE_U:  begin flag = (a >= b);                   result = {{(DATA_WIDTH-1){1'b0}}, flag}; end
      ALU_SLT:   begin flag = ($signed(a) < $signed(b));  result = {{(DATA_WIDTH-1){1'b0}}, flag}; end
      ALU_SLT_U: begin flag = (a < b);                    result = {{(DATA_WIDTH-1){1'b0}}, flag}; end
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: one-cycle ops via alu_logic_unit; shifts either barrel (FAST_SHIFT=1)
// or serial 1 bit/cycle with a start/busy/done handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FAST_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [3:0]            ALU_OP_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] work;
  logic [SHW-1:0]        cnt;
  alu_op_t               op_q;

  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] lu_res, shift_res, one_res, step;
  logic                  go_serial;

  assign shamt = B_i[SHW-1:0];

  alu_logic_unit #(.DATA_WIDTH(DATA_WIDTH)) u_logic (
    .op     (ALU_OP_i),
    .a      (A_i),
    .b      (B_i),
    .result (lu_res)
  );

  generate
    if (FAST_SHIFT != 0) begin : g_barrel
      always_comb begin
        shift_res = A_i;
        case (ALU_OP_i)
          ALU_SLL: shift_res = A_i << shamt;
          ALU_SRL: shift_res = A_i >> shamt;
          ALU_SRA: shift_res = $unsigned($signed(A_i) >>> shamt);
          default: shift_res = A_i;
        endcase
      end
    end else begin : g_serial
      // only the shamt==0 case completes in one cycle here
      assign shift_res = A_i;
    end
  endgenerate

  assign one_res   = is_shift_op(ALU_OP_i) ? shift_res : lu_res;
  assign go_serial = (FAST_SHIFT == 0) && is_shift_op(ALU_OP_i) && (shamt != '0);

  always_comb begin
    step = work;
    case (op_q)
      ALU_SLL: step = {work[DATA_WIDTH-2:0], 1'b0};
      ALU_SRL: step = {1'b0, work[DATA_WIDTH-1:1]};
      ALU_SRA: step = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
      default: step = work;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      op_q     <= ALU_AND;
      result_o <= '0;
      zero_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          // flush wins over a coincident start
          if (start_i && !flush_i) begin
            if (go_serial) begin
              work  <= A_i;
              op_q  <= ALU_OP_i;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              result_o <= one_res;
              zero_o   <= (one_res == '0);
              done_o   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (flush_i) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            work <= step;
            cnt  <= cnt - 1'b1;
            if (cnt == SHW'(1)) begin
              result_o <= step;
              zero_o   <= (step == '0);
              done_o   <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state == SHIFT);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (serial shifter) with a cycle-level reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  ALU_OP_i = 4'b0;
  logic [31:0] A_i = '0;
  logic [31:0] B_i = '0;
  logic        busy_o, done_o, zero_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  alu_multicycle #(.DATA_WIDTH(32), .FAST_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
    .ALU_OP_i(ALU_OP_i), .A_i(A_i), .B_i(B_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the op table
  function automatic logic [31:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return 32'(a == b);
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0111: return $unsigned($signed(a) >>> b[4:0]);
      4'b1000: return a ^ b;
      4'b1001: return ~(a | b);
      4'b1010: return a - b;
      4'b1100: return 32'($signed(a) >= $signed(b));
      4'b1101: return 32'(a >= b);
      4'b1110: return 32'($signed(a) < $signed(b));
      4'b1111: return 32'(a < b);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic is_sh(input logic [3:0] op);
    return op == 4'b0100 || op == 4'b0101 || op == 4'b0111;
  endfunction

  int          m_rem;
  logic [31:0] m_pend, m_res;
  logic        m_zero, m_done;

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] r;
    if (!rst_n) begin
      m_rem <= 0; m_pend <= '0; m_res <= '0; m_zero <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        if (flush_i) m_rem <= 0;
        else begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_res <= m_pend; m_zero <= (m_pend == 0); m_done <= 1'b1;
          end
        end
      end else if (start_i && !flush_i) begin
        r = calc(ALU_OP_i, A_i, B_i);
        if (is_sh(ALU_OP_i) && B_i[4:0] != 5'd0) begin
          m_rem <= int'(B_i[4:0]); m_pend <= r;
        end else begin
          m_res <= r; m_zero <= (r == 0); m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy", 32'(busy_o), 32'(m_rem > 0));
      check("cyc done", 32'(done_o), 32'(m_done));
      check("cyc result", result_o, m_res);
      check("cyc zero", 32'(zero_o), 32'(m_zero));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Start one op, wait (bounded) for done_o; check latency, busy cycles and literal result.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input int elat, input int poke);
    int lat, nb, extra;
    start_i = 1'b1; ALU_OP_i = op; A_i = a; B_i = b;
    step();
    start_i = 1'b0; A_i = $urandom; B_i = $urandom; ALU_OP_i = 4'($urandom);
    lat = 0; nb = 0; extra = 0;
    while (!done_o && lat < 100) begin
      if (busy_o) nb++;
      start_i = (lat == poke);
      step();
      lat++;
    end
    start_i = 1'b0;
    check({name, " latency"}, 32'(lat), 32'(elat));
    check({name, " busy cycles"}, 32'(nb), 32'(elat));
    check({name, " result"}, result_o, er);
    check({name, " zero"}, 32'(zero_o), 32'(ez));
    if (poke >= 0) begin
      repeat (4) begin step(); if (done_o) extra++; end
      check({name, " extra done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("reset result", result_o, 32'h0);
    check("reset zero", 32'(zero_o), 32'h0);
    check("reset busy", 32'(busy_o), 32'h0);
    check("reset done", 32'(done_o), 32'h0);
    chk_en = 1'b1;

    run_op("SUB 5-5",   4'b1010, 32'd5, 32'd5, 32'h0, 1'b1, 0, -1);
    run_op("SLT",       4'b1110, 32'hFFFF_FFFF, 32'd1, 32'h1, 1'b0, 0, -1);
    run_op("SLT_U",     4'b1111, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 0, -1);
    run_op("SRA 4",     4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4, -1);
    run_op("SRL 4",     4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 4, -1);
    run_op("SLL 31",    4'b0100, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 31, 5);
    run_op("SLL 0",     4'b0100, 32'd1, 32'h20, 32'h1, 1'b0, 0, -1);
    run_op("unused 0110", 4'b0110, 32'h1234, 32'h5678, 32'h0, 1'b1, 0, -1);
    run_op("AND",       4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 0, -1);
    run_op("OR",        4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 0, -1);
    run_op("SUM wrap",  4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 0, -1);
    run_op("NOR",       4'b1001, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, -1);
    run_op("EQUAL",     4'b0011, 32'd7, 32'd7, 32'h1, 1'b0, 0, -1);
    run_op("GE signed", 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 0, -1);
    run_op("GE_U",      4'b1101, 32'hFFFF_FFFF, 32'd1, 32'h1, 1'b0, 0, -1);
    run_op("SUB neg",   4'b1010, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 0, -1);
    run_op("unused 1011", 4'b1011, 32'd9, 32'd9, 32'h0, 1'b1, 0, -1);
    run_op("XOR",       4'b1000, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 0, -1);

    // back-to-back starts every cycle
    start_i = 1'b1; ALU_OP_i = 4'b0010; A_i = 32'd1; B_i = 32'd2;
    step(); check("burst0", result_o, 32'd3); check("burst0 done", 32'(done_o), 32'd1);
    ALU_OP_i = 4'b0001; A_i = 32'd4; B_i = 32'd8;
    step(); check("burst1", result_o, 32'd12); check("burst1 done", 32'(done_o), 32'd1);
    ALU_OP_i = 4'b0101; A_i = 32'h10; B_i = 32'h0;
    step(); check("burst2", result_o, 32'h10); check("burst2 done", 32'(done_o), 32'd1);
    start_i = 1'b0;
    run_op("XOR again", 4'b1000, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 0, -1);

    // flush mid-shift: no done, result held
    start_i = 1'b1; ALU_OP_i = 4'b0100; A_i = 32'd3; B_i = 32'd10;
    step(); start_i = 1'b0;
    step(); step();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("flush busy", 32'(busy_o), 32'd0);
    check("flush done", 32'(done_o), 32'd0);
    check("flush result", result_o, 32'h0FF0);
    check("flush zero", 32'(zero_o), 32'd0);
    begin
      int nd = 0;
      repeat (12) begin step(); if (done_o) nd++; end
      check("flush no late done", 32'(nd), 32'd0);
    end

    // reset mid-shift: outputs clear immediately
    start_i = 1'b1; ALU_OP_i = 4'b0100; A_i = 32'd3; B_i = 32'd10;
    step(); start_i = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst result", result_o, 32'h0);
    check("rst zero", 32'(zero_o), 32'd0);
    step(); rst_n = 1'b1;
    step();

    // flush with coincident start in IDLE drops the start
    start_i = 1'b1; flush_i = 1'b1; ALU_OP_i = 4'b0000; A_i = 32'd1; B_i = 32'd1;
    step(); start_i = 1'b0; flush_i = 1'b0;
    check("idle flush done", 32'(done_o), 32'd0);
    check("idle flush result", result_o, 32'h0);
    step(); step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
